truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Stimulus-and-capture stage that sits directly upstream and downstream of a 3-input gate-level logic circuit (ports in1, in2, in3 -> out).
- Drives all 8 input combinations in order, waits a programmable settle time, samples the circuit output, and assembles the measured 8-bit truth table.
- Compares the result against an expected hex truth table and flags per-row mismatches.
- Used in circuit score testing to confirm that each synthesized design implements its target function (e.g. 0xA7).

Parameters:
- SETTLE_CYCLES, 4: clock cycles each combination is held before out is sampled; legal range 1..255.
- CNT_W, 8: width of the settle counter; must hold SETTLE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a sweep; ignored while busy.
- abort  input  1  terminates a sweep in progress; returns to IDLE.
- expected  input  8  target truth table, row 0 at bit 7; sampled on the accepted start.
- dut_out  input  1  output of the circuit under test.
- in1  output  1  circuit input, row index bit 2.
- in2  output  1  circuit input, row index bit 1.
- in3  output  1  circuit input, row index bit 0.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when a sweep completes; not asserted on abort.
- truth_table  output  8  measured table; row k stored at bit 7-k.
- mismatch  output  8  truth_table XOR latched expected; valid when done is high and held afterwards.
- match  output  1  high when mismatch == 0; valid with done and held afterwards.

Behaviour:
- Reset (async assert, synchronous release):
  - in1/in2/in3 = 0, busy = 0, done = 0, truth_table = 0x00, mismatch = 0x00, match = 0.
  - FSM = IDLE, row counter = 0, settle counter = 0.
- Row index k is 3 bits with {in1,in2,in3} = k. Rows are visited 0 through 7 in ascending order.
- FSM states:
  - IDLE:
    - start=1 -> latch expected, clear truth_table, load k=0 and settle counter = SETTLE_CYCLES-1, go to SETTLE.
    - busy rises on the same edge.
  - SETTLE:
    - Counter decrements each cycle.
    - When it reaches 0, the next edge performs the SAMPLE action: truth_table[7-k] <= dut_out.
    - If k<7, that edge also increments k, drives the new inputs, and reloads the counter.
    - If k==7, go to FINISH instead.
    - Each row is therefore presented for exactly SETTLE_CYCLES cycles before its sampling edge.
  - FINISH (one cycle):
    - Compute mismatch and match, pulse done, drop busy, drive inputs to 0, go to IDLE.
- Sweep latency: the accepted start edge is edge 0. The row-7 sample occurs at edge 8*SETTLE_CYCLES. done is high in the cycle after that edge; the next IDLE start can be accepted in the cycle after done.
- A start arriving in the same cycle as done (FSM in FINISH) is ignored.
- Simultaneous start and abort in IDLE: abort wins, and the FSM stays in IDLE.
- abort in SETTLE:
  - Next edge: IDLE, inputs 0, busy 0.
  - truth_table keeps the partially captured bits.
  - mismatch and match are cleared to 0; done is not pulsed.
- dut_out is assumed combinational from in1..in3 in the clk domain. No synchronizer is included.
- Reset asserted mid-sweep: all outputs return to reset values immediately (asynchronous), and no done pulse occurs.
- mismatch, match, and truth_table hold their values in IDLE until the next accepted start.

Test Plan:
- Reference 0xA7 circuit connected, expected=0xA7, SETTLE_CYCLES=4, start pulse -> done at cycle 33 after start, truth_table=0xA7, mismatch=0x00, match=1.
- Same circuit, expected=0xE5 -> truth_table=0xA7, mismatch=0x42, match=0.
- dut_out tied 1, expected=0x00 -> truth_table=0xFF, mismatch=0xFF, match=0.
- Input sequencing check with SETTLE_CYCLES=1:
  - {in1,in2,in3} steps 0..7, one value per cycle, with no repeats or skips.
  - done occurs 9 cycles after start.
- abort asserted while k=3, with dut_out=1:
  - busy drops the next cycle, no done, inputs=0.
  - truth_table=0xE0 (rows 0..2 captured), then match=0 and mismatch=0.
- Extra start pulses during busy are ignored, and a start in the done cycle is ignored. Asserting rst_n=0 mid-sweep clears all outputs asynchronously.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Sweeps the 8 rows of a 3-input circuit, samples its output after a settle time,
// and compares the captured truth table against an expected table.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth_table,
  output logic [7:0] mismatch,
  output logic       match,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       row_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       exp_q;
  logic [7:0]       tt_next;
  logic             sample_now;

  // Handshake: start is a one-cycle request honoured only in IDLE without abort;
  // abort cancels a sweep in SETTLE and suppresses a start in IDLE.
  assign {in1, in2, in3} = row_q;
  assign state_dbg       = state_q;

  always_comb begin
    sample_now       = (state_q == S_SETTLE) && !abort && (cnt_q == '0);
    tt_next          = truth_table;
    tt_next[~row_q]  = dut_out;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start && !abort) state_d = S_SETTLE;
      S_SETTLE: begin
        if (abort) state_d = S_IDLE;
        else if (cnt_q == '0 && row_q == 3'd7) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= 3'd0;
      cnt_q       <= '0;
      exp_q       <= 8'h00;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= 8'h00;
      mismatch    <= 8'h00;
      match       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            exp_q       <= expected;
            truth_table <= 8'h00;
            mismatch    <= 8'h00;
            match       <= 1'b0;
            row_q       <= 3'd0;
            cnt_q       <= RELOAD;
            busy        <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            row_q    <= 3'd0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            mismatch <= 8'h00;
            match    <= 1'b0;
          end else if (!sample_now) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            truth_table <= tt_next;
            if (row_q != 3'd7) begin
              row_q <= row_q + 3'd1;
              cnt_q <= RELOAD;
            end else begin
              // Results are registered on the last sampling edge so they are valid with done.
              row_q    <= 3'd0;
              cnt_q    <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
              mismatch <= tt_next ^ exp_q;
              match    <= (tt_next == exp_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: directed and randomized sweeps against a
// row-by-row reference model, plus abort, reset and start-filtering cases.
module tb_truth_table_sweeper;

  localparam int S0 = 4;
  localparam int S1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, abort0 = 1'b0;
  logic [7:0] exp0 = 8'h00, circ0 = 8'hA7;
  logic       dut_out0, i1_0, i2_0, i3_0, busy0, done0, match0;
  logic [7:0] tt0, mm0;
  logic [1:0] st0;

  logic       start1 = 1'b0, abort1 = 1'b0;
  logic [7:0] exp1 = 8'h00, circ1 = 8'h5A;
  logic       dut_out1, i1_1, i2_1, i3_1, busy1, done1, match1;
  logic [7:0] tt1, mm1;
  logic [1:0] st1;

  // Circuit under test: row k drives its table bit 7-k.
  assign dut_out0 = circ0[~{i1_0, i2_0, i3_0}];
  assign dut_out1 = circ1[~{i1_1, i2_1, i3_1}];

  truth_table_sweeper #(.SETTLE_CYCLES(S0), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .expected(exp0),
    .dut_out(dut_out0), .in1(i1_0), .in2(i2_0), .in3(i3_0), .busy(busy0),
    .done(done0), .truth_table(tt0), .mismatch(mm0), .match(match0), .state_dbg(st0)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(S1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .expected(exp1),
    .dut_out(dut_out1), .in1(i1_1), .in2(i2_1), .in3(i3_1), .busy(busy1),
    .done(done1), .truth_table(tt1), .mismatch(mm1), .match(match1), .state_dbg(st1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: evaluate the circuit once per row index and place it at bit 7-k.
  function automatic logic [7:0] model_tt(input logic [7:0] circ);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < 8; k++) r[7-k] = circ[7-k];
    return r;
  endfunction

  task automatic sweep0(input logic [7:0] circ, input logic [7:0] e, input bit noise);
    int cyc, seq_err;
    bit got;
    logic [7:0] want;
    circ0 = circ;
    exp_q.push_back(model_tt(circ));
    @(negedge clk);
    start0 = 1'b1;
    exp0   = e;
    @(negedge clk);
    start0 = 1'b0;
    exp0   = 8'($urandom);
    cyc = 1; seq_err = 0; got = 1'b0;
    chk("busy_rise", busy0, 1);
    while (cyc <= 8*S0 + 5) begin
      if (done0) begin got = 1'b1; break; end
      if ({i1_0, i2_0, i3_0} !== 3'((cyc-1)/S0)) seq_err++;
      if (busy0 !== 1'b1) seq_err++;
      start0 = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
      cyc++;
    end
    want = exp_q.pop_front();
    chk("done_seen", got, 1);
    chk("done_cycle", cyc, 8*S0 + 1);
    chk("row_sequence", seq_err, 0);
    chk("truth_table", tt0, want);
    chk("mismatch", mm0, want ^ e);
    chk("match", match0, (want == e));
    chk("busy_low_at_done", busy0, 0);
    chk("inputs_zero_at_done", {i1_0, i2_0, i3_0}, 0);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("done_single_pulse", done0, 0);
    chk("start_in_done_ignored", busy0, 0);
    chk("result_held", {tt0, mm0, 7'd0, match0}, {want, want ^ e, 7'd0, (want == e)});
  endtask

  initial begin
    int cyc, seq_err, dcount;
    bit got;
    logic [7:0] r, e;

    repeat (2) @(negedge clk);
    chk("reset_busy", busy0, 0);
    chk("reset_done", done0, 0);
    chk("reset_inputs", {i1_0, i2_0, i3_0}, 0);
    chk("reset_tt_mm_match", {tt0, mm0, 7'd0, match0}, 0);
    chk("reset_state", st0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    sweep0(8'hA7, 8'hA7, 1'b0);
    sweep0(8'hA7, 8'hE5, 1'b0);
    sweep0(8'hFF, 8'h00, 1'b0);
    for (int n = 0; n < 6; n++) begin
      r = 8'($urandom);
      e = ($urandom_range(0, 1) == 1) ? r : 8'($urandom);
      sweep0(r, e, 1'b1);
    end

    // Input sequencing with one-cycle settle on the second instance.
    @(negedge clk);
    start1 = 1'b1; exp1 = 8'h5A;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 1; seq_err = 0; got = 1'b0;
    while (cyc <= 14) begin
      if (done1) begin got = 1'b1; break; end
      if ({i1_1, i2_1, i3_1} !== 3'(cyc-1)) seq_err++;
      @(negedge clk);
      cyc++;
    end
    chk("s1_done_seen", got, 1);
    chk("s1_done_cycle", cyc, 9);
    chk("s1_sequence", seq_err, 0);
    chk("s1_tt", tt1, model_tt(8'h5A));
    chk("s1_match", match1, 1);

    // Abort while row 3 is presented with the output tied high.
    circ0 = 8'hFF;
    @(negedge clk);
    start0 = 1'b1; exp0 = 8'h00;
    @(negedge clk);
    start0 = 1'b0;
    cyc = 1;
    while ({i1_0, i2_0, i3_0} !== 3'd3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_row3_cycle", cyc, 3*S0 + 1);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk("abort_busy", busy0, 0);
    chk("abort_inputs", {i1_0, i2_0, i3_0}, 0);
    chk("abort_tt", tt0, 8'hE0);
    chk("abort_mm_match", {mm0, match0}, 0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done0) dcount++;
      @(negedge clk);
    end
    chk("abort_no_done", dcount, 0);

    // Simultaneous start and abort in idle.
    start0 = 1'b1; abort0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; abort0 = 1'b0;
    chk("start_abort_idle", busy0, 0);
    chk("start_abort_tt_held", tt0, 8'hE0);

    // Reset in the middle of a sweep after two rows are captured.
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (2*S0 + 1) @(negedge clk);
    chk("pre_reset_tt", tt0, 8'hC0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_busy", busy0, 0);
    chk("async_reset_inputs", {i1_0, i2_0, i3_0}, 0);
    chk("async_reset_outputs", {tt0, mm0, 6'd0, match0, done0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done0 || busy0) dcount++;
      @(negedge clk);
    end
    chk("post_reset_idle", dcount, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
